// File: rtl/cpu_run_controller.sv
// Run controller for the 8-bit single-cycle processor: owns the 256x8
// instruction memory, loads it through a valid/ready byte stream while the
// processor is held in reset, and gates processor commits for free-run,
// single-step and breakpoint operation.
module cpu_run_controller (
  input  logic       CLK,
  input  logic       reset,
  input  logic       load_req,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  input  logic       run,
  input  logic       step,
  input  logic       halt_en,
  input  logic [7:0] halt_addr,
  input  logic [7:0] read_address,
  output logic [7:0] instruction,
  output logic       cpu_en,
  output logic       cpu_reset_n,
  output logic [1:0] state,
  output logic [8:0] load_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_RUN   = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  state_t     state_r;
  state_t     next_state;
  logic       step_q;
  logic       first_run;
  logic       bp_hit;
  logic       step_fire;
  logic       load_accept;
  logic [7:0] mem [0:255];

  assign state = state_r;

  // A byte in the cycle load_req falls is refused: the block leaves LOAD.
  assign load_ready  = (state_r == S_LOAD) & ~load_count[8];
  assign load_accept = load_valid & load_ready & load_req;

  // Locations beyond the loaded program read as 0x00 (NOP-like).
  assign instruction = ({1'b0, read_address} < load_count) ? mem[read_address] : 8'h00;

  // The first RUN cycle after IDLE ignores the breakpoint so a resumed run
  // can execute the instruction sitting at halt_addr.
  assign bp_hit    = halt_en & (read_address == halt_addr) & ~first_run;
  assign step_fire = step & ~step_q & ((state_r == S_IDLE) | (state_r == S_BREAK)) & ~load_req;
  assign cpu_en    = ((state_r == S_RUN) & run & ~load_req & ~bp_hit) | step_fire;

  // Next-state selection in priority order; load_req overrides everything.
  always_comb begin
    next_state = state_r;
    if (load_req) begin
      next_state = S_LOAD;
    end else begin
      case (state_r)
        S_LOAD:  next_state = S_IDLE;
        S_IDLE:  if (run) next_state = S_RUN;
        S_RUN: begin
          if (!run)        next_state = S_IDLE;
          else if (bp_hit) next_state = S_BREAK;
        end
        S_BREAK: if (!run) next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Controller state, load counter and registered processor reset.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      load_count  <= 9'd0;
      cpu_reset_n <= 1'b0;
      step_q      <= 1'b1;
      first_run   <= 1'b0;
    end else begin
      state_r     <= next_state;
      cpu_reset_n <= (next_state != S_LOAD);
      step_q      <= step;
      first_run   <= (state_r == S_IDLE) & (next_state == S_RUN);
      if ((state_r != S_LOAD) && (next_state == S_LOAD)) begin
        load_count <= 9'd0;
      end else if (load_accept) begin
        load_count <= load_count + 9'd1;
      end
    end
  end

  // Instruction memory write port; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (load_accept) begin
      mem[load_count[7:0]] <= load_data;
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with a trivial processor PC model
// (PC clears while held in reset, increments on each enabled edge).
module tb_cpu_run_controller;

  logic       CLK = 1'b0;
  logic       reset;
  logic       load_req;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       run;
  logic       step;
  logic       halt_en;
  logic [7:0] halt_addr;
  logic [7:0] read_address;
  logic [7:0] instruction;
  logic       cpu_en;
  logic       cpu_reset_n;
  logic [1:0] state;
  logic [8:0] load_count;

  logic [7:0] pc;
  logic       use_ovr;
  logic [7:0] addr_ovr;
  int         en_cnt;
  int         errors = 0;
  int         checks = 0;
  int         en_base;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t tbl_small [5];
  rd_vec_t tbl_full  [4];

  cpu_run_controller dut (
    .CLK(CLK), .reset(reset), .load_req(load_req), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .run(run), .step(step),
    .halt_en(halt_en), .halt_addr(halt_addr), .read_address(read_address),
    .instruction(instruction), .cpu_en(cpu_en), .cpu_reset_n(cpu_reset_n),
    .state(state), .load_count(load_count)
  );

  always #5 CLK = ~CLK;

  assign read_address = use_ovr ? addr_ovr : pc;

  // Processor PC model.
  always @(posedge CLK or negedge reset) begin
    if (!reset)            pc <= 8'd0;
    else if (!cpu_reset_n) pc <= 8'd0;
    else if (cpu_en)       pc <= pc + 8'd1;
  end

  // Count committed cycles.
  always @(posedge CLK or negedge reset) begin
    if (!reset)      en_cnt <= 0;
    else if (cpu_en) en_cnt <= en_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic nedge(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  initial begin
    tbl_small[0] = '{8'd0,   8'h14};
    tbl_small[1] = '{8'd1,   8'h58};
    tbl_small[2] = '{8'd2,   8'hC3};
    tbl_small[3] = '{8'd3,   8'h00};
    tbl_small[4] = '{8'd255, 8'h00};
    tbl_full[0]  = '{8'd0,   8'h5A};
    tbl_full[1]  = '{8'd1,   8'h5B};
    tbl_full[2]  = '{8'd128, 8'hDA};
    tbl_full[3]  = '{8'd255, 8'hA5};

    reset = 1'b0; load_req = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    run = 1'b0; step = 1'b1; halt_en = 1'b0; halt_addr = 8'h00;
    use_ovr = 1'b0; addr_ovr = 8'h00;

    // Reset with step held high
    #23;
    check("rst_state", state, 0);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_cpu_reset_n", cpu_reset_n, 0);
    check("rst_load_count", load_count, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_instruction", instruction, 0);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    check("cpu_reset_n_rise", cpu_reset_n, 1);
    nedge(2);
    check("step_held_no_fire", en_cnt, 0);
    step = 1'b0;
    @(negedge CLK);

    // Load three bytes
    load_req = 1'b1;
    @(negedge CLK);
    check("load_state", state, 1);
    check("load_ready_entry", load_ready, 1);
    check("load_cpu_reset_n", cpu_reset_n, 0);
    load_valid = 1'b1; load_data = 8'h14;
    @(negedge CLK); load_data = 8'h58;
    @(negedge CLK); load_data = 8'hC3;
    @(negedge CLK);
    check("load_cpu_reset_n_mid", cpu_reset_n, 0);
    check("load_count_3", load_count, 3);
    // Byte presented as load_req falls must be refused
    load_req = 1'b0; load_data = 8'h77;
    @(negedge CLK);
    load_valid = 1'b0;
    check("load_exit_state", state, 0);
    check("load_count_after_drop", load_count, 3);
    check("cpu_reset_n_after_load", cpu_reset_n, 1);
    use_ovr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      addr_ovr = tbl_small[i].addr;
      #1;
      check($sformatf("instr_small_%0d", tbl_small[i].addr), instruction, tbl_small[i].exp);
    end
    use_ovr = 1'b0;

    // Stream 257 bytes with load_valid held high
    @(negedge CLK);
    load_req = 1'b1;
    @(negedge CLK);
    check("reload_count_clear", load_count, 0);
    load_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      load_data = (i == 256) ? 8'hEE : (8'(i) ^ 8'h5A);
      if (i == 255) check("ready_before_full", load_ready, 1);
      @(negedge CLK);
    end
    check("full_load_ready", load_ready, 0);
    check("full_load_count", load_count, 256);
    load_valid = 1'b0; load_req = 1'b0;
    @(negedge CLK);
    use_ovr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr_ovr = tbl_full[i].addr;
      #1;
      check($sformatf("instr_full_%0d", tbl_full[i].addr), instruction, tbl_full[i].exp);
    end
    use_ovr = 1'b0;
    check("pc_zero_after_load", pc, 0);

    // Run to breakpoint at 0x02
    halt_en = 1'b1; halt_addr = 8'h02;
    en_base = en_cnt;
    run = 1'b1;
    nedge(5);
    check("bp_en_cycles", en_cnt - en_base, 2);
    check("bp_state", state, 3);
    check("bp_pc", pc, 2);
    check("bp_cpu_en_low", cpu_en, 0);

    // Three single steps from BREAK
    en_base = en_cnt;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      #1;
      check("step_en_pulse", cpu_en, 1);
      @(negedge CLK);
      check("step_en_once", cpu_en, 0);
      step = 1'b0;
      nedge(3);
    end
    check("step_en_count", en_cnt - en_base, 3);
    check("step_pc", pc, 5);
    check("step_state", state, 3);

    // Resume through the breakpoint address
    halt_addr = 8'h05;
    run = 1'b0;
    @(negedge CLK);
    check("resume_idle", state, 0);
    run = 1'b1;
    @(negedge CLK);
    check("resume_run", state, 2);
    check("resume_pc_at_bp", pc, 5);
    check("resume_first_commit", cpu_en, 1);
    @(negedge CLK);
    check("resume_pc_past", pc, 6);
    check("resume_still_run", state, 2);
    // Step edge in RUN adds nothing
    step = 1'b1;
    @(negedge CLK);
    check("run_step_ignored", pc, 7);
    step = 1'b0;

    // Load request during RUN
    load_req = 1'b1;
    #1;
    check("run_load_en_drop", cpu_en, 0);
    @(negedge CLK);
    check("run_load_state", state, 1);
    check("run_load_count", load_count, 0);
    check("run_load_cpu_reset_n", cpu_reset_n, 0);
    load_valid = 1'b1; load_data = 8'h99;
    nedge(2);
    check("partial_count", load_count, 2);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_count", load_count, 0);
    check("async_rst_state", state, 0);
    check("async_rst_ready", load_ready, 0);
    check("async_rst_cpu_en", cpu_en, 0);
    check("async_rst_cpu_reset_n", cpu_reset_n, 0);
    check("async_rst_instr", instruction, 0);
    load_valid = 1'b0; load_req = 1'b0; run = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    nedge(2);

    // load_req together with a step rise: load wins
    load_req = 1'b1; step = 1'b1;
    #1;
    check("load_vs_step_en", cpu_en, 0);
    @(negedge CLK);
    check("load_vs_step_state", state, 1);
    load_req = 1'b0; step = 1'b0;
    nedge(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
